uart_echo_fifo: RTL and testbench

UART_ECHO_FIFO -- requirements
Module: uart_echo_fifo

---
 rtl/uart_echo_fifo.sv | 189 ++++++++++++++++++
 tb/tb_uart_echo_fifo.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: 16x-oversampled UART receiver feeding a FWFT FIFO that drains either to the host
// or straight back out through the transmitter.
module uart_echo_fifo #(
  parameter int OVS_DIV    = 35,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_pin,
  output logic                          tx_pin,
  input  logic                          echo_en,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(OVS_DIV);
  localparam int BW = $clog2(DATA_BITS + 1);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  logic [DW-1:0] div_q, div_d;
  logic [2:0] sync_q, sync_d;
  state_t rx_st_q, rx_st_d, tx_st_q, tx_st_d;
  logic [3:0] rx_tk_q, rx_tk_d, tx_tk_q, tx_tk_d;
  logic [BW-1:0] rx_bit_q, rx_bit_d, tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d, ld_data;
  logic rx_par_q, rx_par_d, wr_q, wr_d, ferr_q, ferr_d, perr_q, perr_d, ovr_q, ovr_d;
  logic tx_par_q, tx_par_d, tx_q, tx_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic tick, rx_mid, tx_end, tx_idle, load_fifo, load, push, pop, full;
  // sync_q[1] is the synchronized line, sync_q[2] its previous value for falling-edge detect
  always_comb begin
    tick = div_q == DW'(OVS_DIV - 1);
    div_d = tick ? '0 : div_q + 1'b1;
    sync_d = {sync_q[1:0], rx_pin};
    rx_mid = tick && rx_tk_q == 4'hf;
    rx_st_d = rx_st_q;
    rx_tk_d = rx_st_q == S_IDLE ? '0 : rx_tk_q + 4'(tick);
    rx_bit_d = rx_bit_q;
    rx_sh_d = rx_sh_q;
    rx_par_d = rx_par_q;
    wr_d = 1'b0;
    ferr_d = 1'b0;
    perr_d = 1'b0;
    case (rx_st_q)
      S_IDLE: if (sync_q[2] && !sync_q[1]) rx_st_d = S_START;
      S_START: if (tick && rx_tk_q == 4'd7) begin
        rx_st_d = sync_q[1] ? S_IDLE : S_DATA;
        rx_tk_d = '0;
        rx_bit_d = '0;
      end
      S_DATA: if (rx_mid) begin
        rx_sh_d = {sync_q[1], rx_sh_q[DATA_BITS-1:1]};
        rx_bit_d = rx_bit_q + 1'b1;
        if (rx_bit_q == BW'(DATA_BITS - 1)) rx_st_d = PARITY != 0 ? S_PARITY : S_STOP;
      end
      S_PARITY: if (rx_mid) begin
        rx_par_d = sync_q[1];
        rx_st_d = S_STOP;
      end
      S_STOP: if (rx_mid) begin
        ferr_d = !sync_q[1];
        perr_d = PARITY != 0 && ((^rx_sh_q ^ rx_par_q) != (PARITY == 1));
        wr_d = sync_q[1] && !perr_d;
        rx_st_d = S_IDLE;
      end
      default: rx_st_d = S_IDLE;
    endcase
  end
  // The transmitter and the host both pop from the FIFO head; echo_en picks which one may.
  always_comb begin
    tx_idle = tx_st_q == S_IDLE;
    rx_data = mem_q[rp_q];
    rx_valid = !echo_en && cnt_q != '0;
    tx_ready = !rst && !echo_en && tx_idle;
    load_fifo = echo_en && tx_idle && cnt_q != '0;
    load = load_fifo || (tx_valid && tx_ready);
    full = cnt_q == (AW+1)'(FIFO_DEPTH);
    pop = (rx_valid && rx_ready) || load_fifo;
    push = wr_q && (!full || pop);
    ovr_d = wr_q && full && !pop;
    wp_d = wp_q + AW'(push);
    rp_d = rp_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    ld_data = echo_en ? rx_data : tx_data;
    tx_end = tick && tx_tk_q == 4'hf;
    tx_st_d = tx_st_q;
    tx_tk_d = tx_idle ? '0 : tx_tk_q + 4'(tick);
    tx_bit_d = tx_bit_q;
    tx_sh_d = tx_sh_q;
    tx_par_d = tx_par_q;
    tx_d = tx_q;
    case (tx_st_q)
      S_IDLE: if (load) begin
        tx_st_d = S_START;
        tx_d = 1'b0;
        tx_bit_d = '0;
        tx_sh_d = ld_data;
        tx_par_d = (^ld_data) ^ (PARITY == 1);
      end
      S_START: if (tx_end) begin
        tx_st_d = S_DATA;
        tx_d = tx_sh_q[0];
      end
      S_DATA: if (tx_end) begin
        if (tx_bit_q == BW'(DATA_BITS - 1)) begin
          tx_st_d = PARITY != 0 ? S_PARITY : S_STOP;
          tx_d = PARITY != 0 ? tx_par_q : 1'b1;
          tx_bit_d = '0;
        end else begin
          tx_sh_d = tx_sh_q >> 1;
          tx_d = tx_sh_q[1];
          tx_bit_d = tx_bit_q + 1'b1;
        end
      end
      S_PARITY: if (tx_end) begin
        tx_st_d = S_STOP;
        tx_d = 1'b1;
      end
      S_STOP: if (tx_end) begin
        tx_bit_d = tx_bit_q + 1'b1;
        if (tx_bit_q == BW'(STOP_BITS - 1)) tx_st_d = S_IDLE;
      end
      default: tx_st_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      div_q <= '0;
      sync_q <= '1;
      rx_st_q <= S_IDLE;
      rx_tk_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q <= '0;
      rx_par_q <= 1'b0;
      wr_q <= 1'b0;
      ferr_q <= 1'b0;
      perr_q <= 1'b0;
      ovr_q <= 1'b0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      tx_st_q <= S_IDLE;
      tx_tk_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q <= '0;
      tx_par_q <= 1'b0;
      tx_q <= 1'b1;
    end else begin
      div_q <= div_d;
      sync_q <= sync_d;
      rx_st_q <= rx_st_d;
      rx_tk_q <= rx_tk_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q <= rx_sh_d;
      rx_par_q <= rx_par_d;
      wr_q <= wr_d;
      ferr_q <= ferr_d;
      perr_q <= perr_d;
      ovr_q <= ovr_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      tx_st_q <= tx_st_d;
      tx_tk_q <= tx_tk_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q <= tx_sh_d;
      tx_par_q <= tx_par_d;
      tx_q <= tx_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wp_q] <= rx_sh_q;
  assign tx_pin = tx_q;
  assign frame_err = ferr_q;
  assign parity_err = perr_q;
  assign overrun = ovr_q;
  assign fifo_count = cnt_q;
endmodule

// File: tb/tb_uart_echo_fifo.sv
// tb_uart_echo_fifo: directed vectors for uart_echo_fifo at 64 clk/bit, one no-parity and one even-parity instance.
module tb_uart_echo_fifo;
  logic clk = 1'b0, rst = 1'b1;
  logic rx0 = 1'b1, tx0, echo0 = 1'b0, rxv0, rxr0 = 1'b0, txv0 = 1'b0, txr0, fe0, pe0, ov0;
  logic rx2 = 1'b1, tx2, echo2 = 1'b0, rxv2, rxr2 = 1'b0, txv2 = 1'b0, txr2, fe2, pe2, ov2;
  logic [7:0] rxd0, txd0 = '0, rxd2, txd2 = '0;
  logic [4:0] cnt0, cnt2;
  int checks = 0, failures = 0;
  int nf0 = 0, np0 = 0, no0 = 0, nf2 = 0, np2 = 0, no2 = 0;
  int bf, bp, bo;
  typedef struct { logic [7:0] d; logic stop; int ferr; int cnt; } vec_t;
  vec_t vt [5];

  always #5 clk = ~clk;

  uart_echo_fifo #(.OVS_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) dut0 (
    .clk(clk), .rst(rst), .rx_pin(rx0), .tx_pin(tx0), .echo_en(echo0),
    .rx_data(rxd0), .rx_valid(rxv0), .rx_ready(rxr0), .tx_data(txd0), .tx_valid(txv0), .tx_ready(txr0),
    .frame_err(fe0), .parity_err(pe0), .overrun(ov0), .fifo_count(cnt0));

  uart_echo_fifo #(.OVS_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) dut2 (
    .clk(clk), .rst(rst), .rx_pin(rx2), .tx_pin(tx2), .echo_en(echo2),
    .rx_data(rxd2), .rx_valid(rxv2), .rx_ready(rxr2), .tx_data(txd2), .tx_valid(txv2), .tx_ready(txr2),
    .frame_err(fe2), .parity_err(pe2), .overrun(ov2), .fifo_count(cnt2));

  always @(negedge clk) begin
    if (fe0) nf0++;
    if (pe0) np0++;
    if (ov0) no0++;
    if (fe2) nf2++;
    if (pe2) np2++;
    if (ov2) no2++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic pin(input int w);
    return w == 0 ? tx0 : tx2;
  endfunction

  task automatic drive_bit(input int w, input logic b);
    if (w == 0) rx0 = b; else rx2 = b;
    repeat (64) @(posedge clk);
  endtask

  // par < 0 means no parity bit; one idle bit follows so the stop sample and FIFO write complete
  task automatic send_frame(input int w, input logic [7:0] d, input int par, input logic stop);
    drive_bit(w, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(w, d[i]);
    if (par >= 0) drive_bit(w, par[0]);
    drive_bit(w, stop);
    drive_bit(w, 1'b1);
  endtask

  task automatic host_tx(input int w, input logic [7:0] d);
    bit rdy;
    rdy = 1'b0;
    @(negedge clk);
    if (w == 0) begin txd0 = d; txv0 = 1'b1; end else begin txd2 = d; txv2 = 1'b1; end
    for (int i = 0; i < 2000 && !rdy; i++) begin
      if ((w == 0 ? txr0 : txr2) === 1'b1) rdy = 1'b1;
      else @(negedge clk);
    end
    check("host_tx_ready_timeout", 32'(rdy), 32'd1);
    @(posedge clk);
    #1;
    txv0 = 1'b0;
    txv2 = 1'b0;
  endtask

  task automatic pop(input int w);
    @(negedge clk);
    if (w == 0) rxr0 = 1'b1; else rxr2 = 1'b1;
    @(negedge clk);
    rxr0 = 1'b0;
    rxr2 = 1'b0;
  endtask

  // exp holds the frame in wire order: bit 0 is the start bit
  task automatic capture(input int w, input logic [10:0] exp, input int n, input string name);
    bit seen;
    int k;
    logic [10:0] got;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (pin(w) == 1'b0) seen = 1'b1;
    end
    check({name, "_start_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      k = 0;
      while (pin(w) == 1'b0 && k < 200) begin
        @(negedge clk);
        k++;
      end
      check({name, "_start_width_ok"}, 32'(k >= 60 && k <= 68), 32'd1);
      got = '0;
      repeat (96 - k) @(negedge clk);
      for (int i = 1; i < n; i++) begin
        got[i] = pin(w);
        if (i < n - 1) repeat (64) @(negedge clk);
      end
      check({name, "_bits"}, 32'(got), 32'(exp));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{8'h55, 1'b0, 1, 0};
    vt[1] = '{8'h12, 1'b1, 0, 1};
    vt[2] = '{8'hFF, 1'b1, 0, 1};
    vt[3] = '{8'h00, 1'b0, 1, 0};
    vt[4] = '{8'h80, 1'b1, 0, 1};

    repeat (5) @(negedge clk);
    check("rst_tx_pin", 32'(tx0), 32'd1);
    check("rst_tx_ready", 32'(txr0), 32'd0);
    check("rst_rx_valid", 32'(rxv0), 32'd0);
    check("rst_fifo_count", 32'(cnt0), 32'd0);
    check("rst_errs", 32'({fe0, pe0, ov0}), 32'd0);
    rst = 1'b0;
    #1;
    check("tx_ready_after_rst", 32'(txr0), 32'd1);

    echo0 = 1'b1;
    #1;
    check("echo_tx_ready", 32'(txr0), 32'd0);
    fork
      send_frame(0, 8'hA5, -1, 1'b1);
      capture(0, {1'b1, 8'hA5, 1'b0}, 10, "echo_a5");
    join
    @(negedge clk);
    check("echo_fifo_empty", 32'(cnt0), 32'd0);
    check("echo_rx_valid", 32'(rxv0), 32'd0);
    echo0 = 1'b0;

    for (int v = 0; v < 5; v++) begin
      bf = nf0;
      send_frame(0, vt[v].d, -1, vt[v].stop);
      @(negedge clk);
      check($sformatf("vec%0d_frame_err", v), 32'(nf0 - bf), 32'(vt[v].ferr));
      check($sformatf("vec%0d_count", v), 32'(cnt0), 32'(vt[v].cnt));
      if (vt[v].cnt != 0) begin
        check($sformatf("vec%0d_rx_valid", v), 32'(rxv0), 32'd1);
        check($sformatf("vec%0d_rx_data", v), 32'(rxd0), 32'(vt[v].d));
        pop(0);
      end
    end

    bf = nf0; bo = no0;
    rx0 = 1'b0;
    repeat (24) @(posedge clk);
    rx0 = 1'b1;
    repeat (700) @(posedge clk);
    @(negedge clk);
    check("glitch_count", 32'(cnt0), 32'd0);
    check("glitch_errs", 32'(nf0 - bf + no0 - bo), 32'd0);

    bo = no0;
    for (int i = 0; i <= 16; i++) send_frame(0, 8'(i), -1, 1'b1);
    @(negedge clk);
    check("ovr_count_full", 32'(cnt0), 32'd16);
    check("ovr_pulses", 32'(no0 - bo), 32'd1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("ovr_read%0d", i), 32'(rxd0), 32'(i));
      pop(0);
    end
    @(negedge clk);
    check("ovr_drained", 32'(cnt0), 32'd0);

    bp = np2;
    send_frame(2, 8'h3C, 1, 1'b1);
    @(negedge clk);
    check("par_bad_pulse", 32'(np2 - bp), 32'd1);
    check("par_bad_count", 32'(cnt2), 32'd0);
    send_frame(2, 8'h3C, 0, 1'b1);
    @(negedge clk);
    check("par_good_valid", 32'(rxv2), 32'd1);
    check("par_good_data", 32'(rxd2), 32'h3C);
    check("par_good_no_err", 32'(np2 - bp), 32'd1);
    pop(2);
    host_tx(2, 8'h07);
    capture(2, {1'b1, 1'b1, 8'h07, 1'b0}, 11, "tx_even_07");

    send_frame(0, 8'h33, -1, 1'b1);
    @(negedge clk);
    check("pre_rst_count", 32'(cnt0), 32'd1);
    host_tx(0, 8'hF0);
    repeat (285) @(posedge clk);
    @(negedge clk);
    check("bit3_low", 32'(tx0), 32'd0);
    rst = 1'b1;
    #1;
    check("midrst_tx_pin", 32'(tx0), 32'd1);
    check("midrst_tx_ready", 32'(txr0), 32'd0);
    check("midrst_count", 32'(cnt0), 32'd0);
    check("midrst_rx_valid", 32'(rxv0), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_release_ready", 32'(txr0), 32'd1);
    host_tx(0, 8'h81);
    capture(0, {1'b1, 8'h81, 1'b0}, 10, "tx_81");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
